// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// The arbiter side drives the grant signals (master); requesters drive req (slave).
interface rr_arbiter8_if #(
    parameter int N     = 8,
    parameter int IDX_W = 3
);
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;

    modport master (
        input  req,
        output grant,
        output grant_idx,
        output grant_valid
    );

    modport slave (
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid
    );
endinterface

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters: registered one-hot grant, binary index,
// and a hold-time limit that forces a handoff when others are waiting.
module rr_arbiter8 #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arbiter8_if.master  bus
);

    localparam int HCNT_W   = $clog2(MAX_HOLD) + 1;
    localparam bit LIMIT_EN = (MAX_HOLD != 0);
    // With the limit disabled the counter simply parks at all-ones.
    localparam logic [HCNT_W-1:0] HOLD_LAST =
        HCNT_W'(LIMIT_EN ? MAX_HOLD - 1 : (1 << HCNT_W) - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;

    logic [IDX_W-1:0]  search_base;
    logic [N-1:0]      search_req;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic              others_any;
    logic              handoff;

    // The current owner is masked out, so a timed-out owner cannot re-win.
    assign search_req = bus.req & ~grant_q;
    assign search_base = (state_q == GRANT) ? idx_q + IDX_W'(1) : ptr_q;
    assign others_any  = |search_req;
    assign handoff     = (state_q == GRANT) &&
                         (!bus.req[idx_q] ||
                          (LIMIT_EN && (hcnt_q == HOLD_LAST) && others_any));

    // Scan from the far end so the last hit is the nearest one to the base.
    always_comb begin
        logic [IDX_W-1:0] cand;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = search_base + IDX_W'(i);
            if (search_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        grant_d = grant_q;
        idx_d   = idx_q;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    grant_d = N'(1) << win_idx;
                    idx_d   = win_idx;
                    hcnt_d  = '0;
                end
            end
            GRANT: begin
                if (handoff) begin
                    ptr_d  = search_base;
                    hcnt_d = '0;
                    if (win_found) begin
                        grant_d = N'(1) << win_idx;
                        idx_d   = win_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        idx_d   = '0;
                    end
                end else if (hcnt_q != HOLD_LAST) begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
        endcase

        valid_d = |grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hcnt_q  <= '0;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values, avoiding simulation races.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: three instances (hold limit 16, 4, disabled) share one
// request vector and are compared every cycle against an owner/pointer model.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;

    int checks   = 0;
    int failures = 0;

    rr_arbiter8_if #(.N(8), .IDX_W(3)) if_a ();
    rr_arbiter8_if #(.N(8), .IDX_W(3)) if_b ();
    rr_arbiter8_if #(.N(8), .IDX_W(3)) if_c ();

    assign if_a.req = req;
    assign if_b.req = req;
    assign if_c.req = req;

    rr_arbiter8 #(.N(8), .IDX_W(3), .MAX_HOLD(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    rr_arbiter8 #(.N(8), .IDX_W(3), .MAX_HOLD(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    rr_arbiter8 #(.N(8), .IDX_W(3), .MAX_HOLD(0))  dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner index (-1 idle), pointer, and how many cycles the owner has held.
    typedef struct {
        int owner;
        int ptr;
        int held;
    } model_t;

    model_t m [3];
    int     max_hold [3] = '{16, 4, 0};

    function automatic int pick(input logic [7:0] r, input int from);
        for (int s = 0; s < 8; s++) begin
            int j = (from + s) % 8;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic void model_reset(input int k);
        m[k].owner = -1;
        m[k].ptr   = 0;
        m[k].held  = 0;
    endfunction

    function automatic void model_step(input int k, input logic [7:0] r);
        int         g;
        logic [7:0] others;
        if (m[k].owner < 0) begin
            if (r != 8'h00) begin
                m[k].owner = pick(r, m[k].ptr);
                m[k].held  = 1;
            end
        end else begin
            g      = m[k].owner;
            others = r & ~(8'h01 << g);
            if (!r[g] || (max_hold[k] != 0 && m[k].held >= max_hold[k] && others != 8'h00)) begin
                m[k].ptr = (g + 1) % 8;
                if (others != 8'h00) begin
                    m[k].owner = pick(others, m[k].ptr);
                    m[k].held  = 1;
                end else begin
                    m[k].owner = -1;
                end
            end else begin
                m[k].held++;
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) model_reset(k);
        end else begin
            for (int k = 0; k < 3; k++) model_step(k, req);
        end
    end

    task automatic cmp(input int k, input string tag, input logic [7:0] g,
                       input logic [2:0] i, input logic v);
        logic [7:0] eg;
        logic [2:0] ei;
        logic       ev;
        eg = (m[k].owner < 0) ? 8'h00 : (8'h01 << m[k].owner);
        ei = (m[k].owner < 0) ? 3'd0 : 3'(m[k].owner);
        ev = (m[k].owner >= 0);
        check({tag, ".grant"}, 32'(g), 32'(eg));
        check({tag, ".grant_idx"}, 32'(i), 32'(ei));
        check({tag, ".grant_valid"}, 32'(v), 32'(ev));
    endtask

    always @(negedge clk) begin
        cmp(0, "a", if_a.grant, if_a.grant_idx, if_a.grant_valid);
        cmp(1, "b", if_b.grant, if_b.grant_idx, if_b.grant_valid);
        cmp(2, "c", if_c.grant, if_c.grant_idx, if_c.grant_valid);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        req = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 8'h00;
        #1 rst_n = 1'b0;
        req = 8'hFF;

        // Reset held with all requests high, then first grant favours requester 0.
        repeat (3) begin
            @(negedge clk);
            check("rst.grant", 32'(if_a.grant), 32'h00);
            check("rst.idx", 32'(if_a.grant_idx), 32'd0);
            check("rst.valid", 32'(if_a.grant_valid), 32'd0);
        end
        rst_n = 1'b1;
        tick(1);
        check("first.grant", 32'(if_a.grant), 32'h01);
        check("first.idx", 32'(if_a.grant_idx), 32'd0);

        // Single requester from idle, then release back to idle.
        req = 8'h00;
        tick(1);
        check("idle.valid", 32'(if_a.grant_valid), 32'd0);
        req = 8'h20;
        tick(1);
        check("r5.grant", 32'(if_a.grant), 32'h20);
        check("r5.idx", 32'(if_a.grant_idx), 32'd5);
        check("r5.valid", 32'(if_a.grant_valid), 32'd1);
        tick(3);
        req = 8'h00;
        tick(1);
        check("r5rel.grant", 32'(if_a.grant), 32'h00);
        check("r5rel.valid", 32'(if_a.grant_valid), 32'd0);

        // Every owner drops its bit right after being granted: 0..7 back to back.
        do_reset();
        req = 8'hFF;
        tick(1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("seq%0d.idx", k), 32'(if_c.grant_idx), 32'(k));
            check($sformatf("seq%0d.valid", k), 32'(if_c.grant_valid), 32'd1);
            req[k] = 1'b0;
            tick(1);
        end
        check("seq.end.valid", 32'(if_c.grant_valid), 32'd0);

        // Wrap-around: owner 6 releases (ptr 7), then 1 beats 3.
        do_reset();
        req = 8'h40;
        tick(1);
        check("wrap.own6", 32'(if_a.grant_idx), 32'd6);
        req = 8'h0A;
        tick(1);
        check("wrap.idx1", 32'(if_a.grant_idx), 32'd1);
        req = 8'h08;
        tick(1);
        check("wrap.idx3", 32'(if_a.grant_idx), 32'd3);
        req = 8'h00;

        // Hold limit of 4 alternates 0 and 2; a lone requester keeps the grant.
        do_reset();
        req = 8'h05;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            check($sformatf("hold%0d.idx", c), 32'(if_b.grant_idx), ((c / 4) % 2 == 1) ? 32'd2 : 32'd0);
        end
        check("hold.nolimit", 32'(if_c.grant_idx), 32'd0);
        req = 8'h01;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            check("alone.idx", 32'(if_b.grant_idx), 32'd0);
            check("alone.valid", 32'(if_b.grant_valid), 32'd1);
        end
        req = 8'h05;
        tick(1);
        check("sat.handoff", 32'(if_b.grant_idx), 32'd2);

        // Asynchronous reset mid-grant clears outputs before the next edge.
        do_reset();
        req = 8'h08;
        tick(1);
        check("ar.pre", 32'(if_a.grant_idx), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("ar.grant", 32'(if_a.grant), 32'h00);
        check("ar.idx", 32'(if_a.grant_idx), 32'd0);
        check("ar.valid", 32'(if_a.grant_valid), 32'd0);
        check("ar.b.valid", 32'(if_b.grant_valid), 32'd0);
        @(negedge clk);
        req   = 8'h88;
        rst_n = 1'b1;
        tick(1);
        check("ar.post.idx", 32'(if_a.grant_idx), 32'd3);
        check("ar.post.grant", 32'(if_a.grant), 32'h08);

        // Random traffic with occasional mid-cycle resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            case ($urandom_range(0, 19))
                0:       req = 8'($urandom);
                1:       req = 8'h00;
                2, 3:    ;
                default: for (int b = 0; b < 8; b++) if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            endcase
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                #6 rst_n = 1'b1;
            end
        end

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
